dmi_arbiter: RTL

//   Shares one DMI target (debug module) between two DMI initiators: M0 = JTAG DTM, M1 = host debug bridge.

---
 rtl/dmi_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dmi_arbiter.sv
// Shares one DMI debug-module target between the JTAG DTM (M0) and the host debug bridge (M1).
// Single-slot request capture per initiator, round-robin grant, one outstanding target access, response timeout.
module dmi_arbiter #(
    parameter int ABITS          = 7,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic [ABITS-1:0] m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [1:0]       m0_op,
    input  logic             m0_req,
    output logic [31:0]      m0_rdata,
    output logic [1:0]       m0_resp,
    output logic             m0_ack,
    output logic             m0_busy_err,
    input  logic             m0_err_clr,
    input  logic [ABITS-1:0] m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [1:0]       m1_op,
    input  logic             m1_req,
    output logic [31:0]      m1_rdata,
    output logic [1:0]       m1_resp,
    output logic             m1_ack,
    output logic             m1_busy_err,
    input  logic             m1_err_clr,
    output logic [ABITS-1:0] s_addr,
    output logic [31:0]      s_wdata,
    output logic [1:0]       s_op,
    output logic             s_req,
    input  logic [31:0]      s_rdata,
    input  logic [1:0]       s_resp,
    input  logic             s_ack,
    output logic             owner,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             pend0, pend1, last_grant;
    logic [ABITS-1:0] slot0_addr, slot1_addr;
    logic [31:0]      slot0_wdata, slot1_wdata;
    logic [1:0]       slot0_op, slot1_op;
    logic [TO_W-1:0]  cnt;

    logic             gnt_vld, gnt;
    logic [ABITS-1:0] g_addr;
    logic [31:0]      g_wdata;
    logic [1:0]       g_op;
    logic             fin, fin_who;
    logic [31:0]      fin_rdata;
    logic [1:0]       fin_resp;

    function automatic logic needs_target(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    // nop completes locally as ok, the reserved op completes locally as failed
    function automatic logic [1:0] local_resp(input logic [1:0] op);
        return (op == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    // Slot payloads are qualified by pendN, so they carry no reset.
    always_ff @(posedge tck) begin
        if (m0_req && !pend0) begin
            slot0_addr  <= m0_addr;
            slot0_wdata <= m0_wdata;
            slot0_op    <= m0_op;
        end
        if (m1_req && !pend1) begin
            slot1_addr  <= m1_addr;
            slot1_wdata <= m1_wdata;
            slot1_op    <= m1_op;
        end
    end

    always_comb begin
        gnt_vld = pend0 | pend1;
        gnt     = 1'b0;
        if (pend0 && pend1) gnt = ~last_grant;
        else if (pend1)     gnt = 1'b1;
    end

    assign g_addr  = gnt ? slot1_addr  : slot0_addr;
    assign g_wdata = gnt ? slot1_wdata : slot0_wdata;
    assign g_op    = gnt ? slot1_op    : slot0_op;

    // An ack in the last WAIT cycle beats the timeout.
    always_comb begin
        fin       = 1'b0;
        fin_who   = owner;
        fin_rdata = '0;
        fin_resp  = 2'b00;
        case (state)
            IDLE: if (gnt_vld && !needs_target(g_op)) begin
                fin      = 1'b1;
                fin_who  = gnt;
                fin_resp = local_resp(g_op);
            end
            WAIT: if (s_ack) begin
                fin       = 1'b1;
                fin_rdata = s_rdata;
                fin_resp  = s_resp;
            end else if (cnt == TO_LAST) begin
                fin      = 1'b1;
                fin_resp = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state       <= IDLE;
            pend0       <= 1'b0;
            pend1       <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_op        <= 2'b00;
            s_req       <= 1'b0;
            m0_rdata    <= '0;
            m0_resp     <= 2'b00;
            m0_ack      <= 1'b0;
            m0_busy_err <= 1'b0;
            m1_rdata    <= '0;
            m1_resp     <= 2'b00;
            m1_ack      <= 1'b0;
            m1_busy_err <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            s_req  <= 1'b0;

            if (m0_req && pend0)   m0_busy_err <= 1'b1;
            else if (m0_err_clr)   m0_busy_err <= 1'b0;
            if (m1_req && pend1)   m1_busy_err <= 1'b1;
            else if (m1_err_clr)   m1_busy_err <= 1'b0;

            if (m0_req && !pend0)                  pend0 <= 1'b1;
            else if (state == RESP && !owner)      pend0 <= 1'b0;
            if (m1_req && !pend1)                  pend1 <= 1'b1;
            else if (state == RESP && owner)       pend1 <= 1'b0;

            case (state)
                IDLE: if (gnt_vld) begin
                    owner      <= gnt;
                    last_grant <= gnt;
                    if (needs_target(g_op)) begin
                        s_addr  <= g_addr;
                        s_wdata <= g_wdata;
                        s_op    <= g_op;
                        s_req   <= 1'b1;
                        cnt     <= '0;
                        state   <= WAIT;
                    end else begin
                        state <= RESP;
                    end
                end
                WAIT: begin
                    if (fin) state <= RESP;
                    else     cnt   <= cnt + 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (fin) begin
                if (fin_who) begin
                    m1_ack   <= 1'b1;
                    m1_rdata <= fin_rdata;
                    m1_resp  <= fin_resp;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_rdata <= fin_rdata;
                    m0_resp  <= fin_resp;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
